// File: rtl/video_fontload.sv
// CPU-side sequencer for the text-mode font RAM: pointer, small write FIFO and bulk fill.
// Font RAM writes are issued only in cend slots, one per slot, with registered outputs.
module video_fontload #(
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        addr_lo_wr,
  input  logic        addr_hi_wr,
  input  logic        data_wr,
  input  logic        fill_start,
  input  logic        cend,
  output logic [10:0] fnt_a,
  output logic [7:0]  fnt_d,
  output logic        fnt_wr,
  output logic [10:0] ptr,
  output logic        busy,
  output logic        ovf,
  output logic        fill_done
);

  localparam int unsigned Depth = 1 << FIFO_LOG2;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e               state_q;
  logic [18:0]          mem_q [Depth];
  logic [FIFO_LOG2-1:0] wr_idx_q, rd_idx_q;
  logic [FIFO_LOG2:0]   count_q;
  logic [10:0]          ptr_q, fcnt_q, fnt_a_q;
  logic [7:0]           fill_val_q, fnt_d_q;
  logic                 fnt_wr_q, fill_done_q, ovf_q;

  logic empty, full, pop, push, fill_go, fill_rej, fill_wr;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (FIFO_LOG2 + 1)'(Depth));
    pop      = (state_q == StIdle) && cend && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push     = data_wr && (!full || pop);
    fill_go  = (state_q == StIdle) && fill_start && empty && !data_wr;
    fill_rej = fill_start && !fill_go;
    fill_wr  = (state_q == StFill) && cend;
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_idx_q] <= {ptr_q, din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      fcnt_q      <= '0;
      fill_val_q  <= '0;
      fnt_a_q     <= '0;
      fnt_d_q     <= '0;
      fnt_wr_q    <= 1'b0;
      fill_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (push) begin
        wr_idx_q <= wr_idx_q + FIFO_LOG2'(1);
      end
      if (pop) begin
        rd_idx_q <= rd_idx_q + FIFO_LOG2'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (FIFO_LOG2 + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_LOG2 + 1)'(1);
        default: count_q <= count_q;
      endcase

      // Address loads take priority over the post-increment of an accepted write.
      if (addr_lo_wr || addr_hi_wr) begin
        if (addr_lo_wr) ptr_q[7:0]  <= din;
        if (addr_hi_wr) ptr_q[10:8] <= din[2:0];
      end else if (push) begin
        ptr_q <= ptr_q + 11'd1;
      end

      if ((data_wr && !push) || fill_rej) begin
        ovf_q <= 1'b1;
      end else if (addr_hi_wr) begin
        ovf_q <= 1'b0;
      end

      fnt_wr_q    <= pop || fill_wr;
      fill_done_q <= fill_wr && (fcnt_q == 11'h7ff);

      if (pop) begin
        {fnt_a_q, fnt_d_q} <= mem_q[rd_idx_q];
      end else if (fill_wr) begin
        fnt_a_q <= fcnt_q;
        fnt_d_q <= fill_val_q;
      end

      unique case (state_q)
        StIdle: begin
          if (fill_go) begin
            fill_val_q <= din;
            fcnt_q     <= '0;
            state_q    <= StFill;
          end
        end
        StFill: begin
          if (fill_wr) begin
            fcnt_q <= fcnt_q + 11'd1;
            if (fcnt_q == 11'h7ff) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fnt_a     = fnt_a_q;
  assign fnt_d     = fnt_d_q;
  assign fnt_wr    = fnt_wr_q;
  assign ptr       = ptr_q;
  assign busy      = (state_q != StIdle) || !empty;
  assign ovf       = ovf_q;
  assign fill_done = fill_done_q;

endmodule

// File: tb/tb_video_fontload.sv
// Bench for video_fontload: expected font writes are queued from the directed scenarios and
// checked in order on every cycle, alongside slot, hold and pulse rules.
module tb_video_fontload;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        addr_lo_wr, addr_hi_wr, data_wr, fill_start, cend;
  logic [10:0] fnt_a, ptr;
  logic [7:0]  fnt_d;
  logic        fnt_wr, busy, ovf, fill_done;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int cend_mode = 0;
  int cend_cnt = 0;
  bit chk_en = 1'b0;
  logic cend_q = 1'b0;
  logic rst_q = 1'b0;
  logic [10:0] last_a;
  logic [7:0]  last_d;
  // Expected write: {fill_done, addr, data}
  logic [19:0] exp_q[$];

  video_fontload #(.FIFO_LOG2(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .addr_lo_wr (addr_lo_wr),
    .addr_hi_wr (addr_hi_wr),
    .data_wr    (data_wr),
    .fill_start (fill_start),
    .cend       (cend),
    .fnt_a      (fnt_a),
    .fnt_d      (fnt_d),
    .fnt_wr     (fnt_wr),
    .ptr        (ptr),
    .busy       (busy),
    .ovf        (ovf),
    .fill_done  (fill_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cend_q <= cend;
    rst_q  <= rst;
  end

  // cend slot generator: 0 = off, 1 = every clk, N = every Nth clk
  always @(posedge clk) begin
    #1;
    cend_cnt = cend_cnt + 1;
    if (cend_mode == 0) cend = 1'b0;
    else cend = ((cend_cnt % cend_mode) == 0);
  end

  always @(negedge clk) begin
    logic [19:0] e;
    if (chk_en) begin
      if (rst_q) begin
        last_a = '0;
        last_d = '0;
      end
      if (fnt_wr) begin
        wr_seen = wr_seen + 1;
        checks = checks + 1;
        if (!(cend_q && !rst_q)) begin
          errors = errors + 1;
          $display("FAIL wr_slot: write with cend=%b rst=%b, required cend=1 rst=0", cend_q, rst_q);
        end
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL spurious_wr: got a=%h d=%h done=%b, required no write", fnt_a, fnt_d,
                   fill_done);
        end else begin
          e = exp_q.pop_front();
          if ({fill_done, fnt_a, fnt_d} !== e) begin
            errors = errors + 1;
            $display("FAIL wr_data: got done=%b a=%h d=%h, required done=%b a=%h d=%h",
                     fill_done, fnt_a, fnt_d, e[19], e[18:8], e[7:0]);
          end
        end
        last_a = fnt_a;
        last_d = fnt_d;
      end else begin
        checks = checks + 1;
        if (fill_done !== 1'b0 || fnt_a !== last_a || fnt_d !== last_d) begin
          errors = errors + 1;
          $display("FAIL hold: got done=%b a=%h d=%h, required done=0 a=%h d=%h",
                   fill_done, fnt_a, fnt_d, last_a, last_d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; callers are never on a posedge.
  task automatic strobe(input logic lo, input logic hi, input logic dw, input logic fs,
                        input logic [7:0] d);
    addr_lo_wr = lo;
    addr_hi_wr = hi;
    data_wr    = dw;
    fill_start = fs;
    din        = d;
    tick();
    addr_lo_wr = 1'b0;
    addr_hi_wr = 1'b0;
    data_wr    = 1'b0;
    fill_start = 1'b0;
    din        = 8'h00;
  endtask

  task automatic set_ptr(input logic [10:0] p);
    strobe(1'b0, 1'b1, 1'b0, 1'b0, {5'b0, p[10:8]});
    strobe(1'b1, 1'b0, 1'b0, 1'b0, p[7:0]);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    @(negedge clk);
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'h0);
    repeat (3) tick();
  endtask

  initial begin
    int base;
    rst = 1'b1;
    din = '0;
    addr_lo_wr = 1'b0;
    addr_hi_wr = 1'b0;
    data_wr = 1'b0;
    fill_start = 1'b0;
    cend = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_fnt_wr", {31'b0, fnt_wr}, 32'h0);
    chk("rst_fnt_a", {21'b0, fnt_a}, 32'h0);
    chk("rst_fnt_d", {24'b0, fnt_d}, 32'h0);
    chk("rst_ptr", {21'b0, ptr}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'h0);
    chk("rst_fill_done", {31'b0, fill_done}, 32'h0);
    last_a = '0;
    last_d = '0;
    chk_en = 1'b1;
    rst = 1'b0;
    tick();

    // Basic pointer/FIFO path
    cend_mode = 4;
    exp_q.push_back({1'b0, 11'h3fe, 8'h11});
    exp_q.push_back({1'b0, 11'h3ff, 8'h22});
    exp_q.push_back({1'b0, 11'h400, 8'h33});
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 8'hfe);
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
    wait_idle(100);
    chk("basic_ptr", {21'b0, ptr}, 32'h401);
    chk("basic_busy", {31'b0, busy}, 32'h0);
    chk("basic_drained", exp_q.size(), 32'h0);

    // Pointer wrap
    set_ptr(11'h7ff);
    exp_q.push_back({1'b0, 11'h7ff, 8'haa});
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 8'haa);
    wait_idle(100);
    chk("wrap_ptr", {21'b0, ptr}, 32'h000);

    // Overflow with cend held low
    cend_mode = 0;
    set_ptr(11'h010);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({1'b0, 11'h010 + 11'(i), 8'(i)});
      strobe(1'b0, 1'b0, 1'b1, 1'b0, 8'(i));
    end
    @(negedge clk);
    chk("ovf_set", {31'b0, ovf}, 32'h1);
    chk("ovf_ptr", {21'b0, ptr}, 32'h014);
    chk("ovf_busy", {31'b0, busy}, 32'h1);
    cend_mode = 4;
    wait_idle(100);
    chk("ovf_drained", exp_q.size(), 32'h0);
    chk("ovf_sticky", {31'b0, ovf}, 32'h1);
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("ovf_clear", {31'b0, ovf}, 32'h0);

    // Fill rejected while a write is pending
    cend_mode = 0;
    set_ptr(11'h020);
    exp_q.push_back({1'b0, 11'h020, 8'h99});
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
    @(negedge clk);
    chk("rej_ovf", {31'b0, ovf}, 32'h1);
    chk("rej_busy", {31'b0, busy}, 32'h1);
    cend_mode = 4;
    wait_idle(100);
    chk("rej_drained", exp_q.size(), 32'h0);
    chk("rej_ptr", {21'b0, ptr}, 32'h021);
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Full fill with a data write queued during it
    set_ptr(11'h123);
    cend_mode = 1;
    for (int i = 0; i < 2048; i++) exp_q.push_back({i == 2047, 11'(i), 8'h55});
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
    repeat (10) tick();
    exp_q.push_back({1'b0, 11'h123, 8'h77});
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
    @(negedge clk);
    chk("fill_busy", {31'b0, busy}, 32'h1);
    chk("fill_ptr", {21'b0, ptr}, 32'h124);
    wait_idle(3000);
    chk("fill_drained", exp_q.size(), 32'h0);
    chk("fill_ovf", {31'b0, ovf}, 32'h0);

    // Reset in the middle of a fill
    for (int i = 0; i < 2048; i++) exp_q.push_back({i == 2047, 11'(i), 8'h3c});
    base = wr_seen;
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 8'h3c);
    for (int i = 0; i < 400 && wr_seen < base + 100; i++) tick();
    chk("midfill_reached", {31'b0, wr_seen >= base + 100}, 32'h1);
    cend_mode = 0;
    repeat (2) tick();
    exp_q.delete();
    cend_mode = 1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("abort_fnt_wr", {31'b0, fnt_wr}, 32'h0);
    chk("abort_fnt_a", {21'b0, fnt_a}, 32'h0);
    chk("abort_fnt_d", {24'b0, fnt_d}, 32'h0);
    chk("abort_ptr", {21'b0, ptr}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_ovf", {31'b0, ovf}, 32'h0);
    rst = 1'b0;
    repeat (20) tick();
    chk("post_abort_idle", {31'b0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
